// File: rtl/game_controller.sv
// Flappy Bird game sequencer: state machine, frame tick divider,
// bird-vs-pipe/floor/ceiling collision and BCD score / high score.
module game_controller #(
  parameter int TICK_DIV    = 1666666,
  parameter int BIRD_SIZE   = 20,
  parameter int PIPE_W      = 40,
  parameter int GAP_H       = 120,
  parameter int SCREEN_H    = 480,
  parameter int DYING_TICKS = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic [9:0]  BirdX,
  input  logic [9:0]  BirdY,
  input  logic [9:0]  PipeX1,
  input  logic [9:0]  PipeX2,
  input  logic [9:0]  PipeY1,
  input  logic [9:0]  PipeY2,
  output logic        Tick,
  output logic        q_I,
  output logic        q_Play,
  output logic        q_Dying,
  output logic        q_End,
  output logic [15:0] Score,
  output logic [15:0] HighScore
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DYING_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DCNT_LAST = CW'(DYING_TICKS - 1);

  typedef enum logic [3:0] {
    S_INIT  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_DYING = 4'b0100,
    S_END   = 4'b1000
  } state_e;

  state_e          state_q;
  logic            tick_q;
  logic [DW-1:0]   div_q;
  logic [CW-1:0]   dcnt_q;
  logic [15:0]     score_q;
  logic [15:0]     hs_q;
  logic            start_q;
  logic            ack_q;
  logic            flag1_q;
  logic            flag2_q;

  logic            start_rise;
  logic            ack_rise;
  logic            running;
  logic            hit;
  logic            pass1;
  logic            pass2;
  logic [15:0]     score_d;

  // 11-bit geometry so edge sums never wrap
  logic [10:0] bx_l;
  logic [10:0] bx_r;
  logic [10:0] by_t;
  logic [10:0] by_b;

  assign bx_l = {1'b0, BirdX};
  assign bx_r = {1'b0, BirdX} + 11'(BIRD_SIZE);
  assign by_t = {1'b0, BirdY};
  assign by_b = {1'b0, BirdY} + 11'(BIRD_SIZE);

  function automatic logic pipe_hit(
    input logic [9:0]  px,
    input logic [9:0]  py,
    input logic [10:0] l,
    input logic [10:0] r,
    input logic [10:0] t,
    input logic [10:0] b
  );
    logic xo;
    logic yo;
    xo = (r > {1'b0, px}) && (l < {1'b0, px} + 11'(PIPE_W));
    yo = (t < {1'b0, py}) || (b > {1'b0, py} + 11'(GAP_H));
    return xo && yo;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_rise = Start & ~start_q;
  assign ack_rise   = Ack & ~ack_q;
  assign running    = (state_q == S_PLAY) || (state_q == S_DYING);

  assign pass1 = ({1'b0, PipeX1} + 11'(PIPE_W)) < bx_l;
  assign pass2 = ({1'b0, PipeX2} + 11'(PIPE_W)) < bx_l;

  assign hit = (by_b >= 11'(SCREEN_H))
             || (BirdY == 10'd0)
             || pipe_hit(PipeX1, PipeY1, bx_l, bx_r, by_t, by_b)
             || pipe_hit(PipeX2, PipeY2, bx_l, bx_r, by_t, by_b);

  // two pipes crossing together chain two saturating increments
  always_comb begin
    score_d = score_q;
    unique case ({pass2 & ~flag2_q, pass1 & ~flag1_q})
      2'b11:        score_d = bcd_inc(bcd_inc(score_q));
      2'b01, 2'b10: score_d = bcd_inc(score_q);
      default:      score_d = score_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      tick_q  <= 1'b0;
      div_q   <= '0;
      dcnt_q  <= '0;
      score_q <= '0;
      hs_q    <= '0;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      flag1_q <= 1'b0;
      flag2_q <= 1'b0;
    end else begin
      start_q <= Start;
      ack_q   <= Ack;
      tick_q  <= 1'b0;
      if (running) begin
        if (div_q == DIV_LAST) begin
          div_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          div_q <= div_q + DW'(1);
        end
      end
      unique case (state_q)
        S_INIT: begin
          if (start_rise) begin
            state_q <= S_PLAY;
            score_q <= '0;
            div_q   <= '0;
            flag1_q <= 1'b0;
            flag2_q <= 1'b0;
          end
        end
        S_PLAY: begin
          if (tick_q) begin
            flag1_q <= pass1;
            flag2_q <= pass2;
            if (hit) begin
              state_q <= S_DYING;
              dcnt_q  <= '0;
            end else begin
              score_q <= score_d;
            end
          end
        end
        S_DYING: begin
          if (tick_q) begin
            if (dcnt_q == DCNT_LAST) begin
              state_q <= S_END;
              if (score_q > hs_q) hs_q <= score_q;
            end else begin
              dcnt_q <= dcnt_q + CW'(1);
            end
          end
        end
        S_END: begin
          if (ack_rise) state_q <= S_INIT;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign Tick      = tick_q;
  assign q_I       = state_q[0];
  assign q_Play    = state_q[1];
  assign q_Dying   = state_q[2];
  assign q_End     = state_q[3];
  assign Score     = score_q;
  assign HighScore = hs_q;

endmodule

// File: tb/tb_game_controller.sv
// Randomised and directed bench for game_controller against a
// cycle-level behavioural model of the game rules.
module tb_game_controller;

  localparam int TD = 4;
  localparam int DT = 30;
  localparam int BS = 20;
  localparam int PW = 40;
  localparam int GH = 120;
  localparam int SH = 480;

  logic        Clk = 1'b0;
  logic        Reset, Start, Ack;
  logic [9:0]  BirdX, BirdY, PipeX1, PipeX2, PipeY1, PipeY2;
  logic        Tick, q_I, q_Play, q_Dying, q_End;
  logic [15:0] Score, HighScore;

  always #5 Clk = ~Clk;

  game_controller #(.TICK_DIV(TD)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .BirdX(BirdX), .BirdY(BirdY),
    .PipeX1(PipeX1), .PipeX2(PipeX2),
    .PipeY1(PipeY1), .PipeY2(PipeY2),
    .Tick(Tick), .q_I(q_I), .q_Play(q_Play),
    .q_Dying(q_Dying), .q_End(q_End),
    .Score(Score), .HighScore(HighScore)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: 0 INIT, 1 PLAY, 2 DYING, 3 END
  int m_st = 0, m_run = 0, m_dc = 0, m_sc = 0, m_hs = 0;
  bit m_tick = 0, m_f1 = 0, m_f2 = 0, m_ps = 0, m_pa = 0;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10),
            4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic bit pipe_hit(input int px, input int py);
    int bx = int'(BirdX);
    int by = int'(BirdY);
    return (bx + BS > px) && (bx < px + PW)
        && ((by < py) || (by + BS > py + GH));
  endfunction

  task automatic model_step();
    bit rs, ra, t, coll, p1, p2;
    int inc;
    if (Reset) begin
      m_st = 0; m_tick = 0; m_run = 0; m_dc = 0;
      m_sc = 0; m_hs = 0; m_f1 = 0; m_f2 = 0; m_ps = 0; m_pa = 0;
      return;
    end
    rs = Start & ~m_ps;
    ra = Ack & ~m_pa;
    m_ps = Start;
    m_pa = Ack;
    t = m_tick;
    case (m_st)
      0: begin
        m_tick = 0;
        if (rs) begin
          m_st = 1; m_sc = 0; m_run = 0; m_f1 = 0; m_f2 = 0;
        end
      end
      1: begin
        m_run++;
        if (t) begin
          coll = (int'(BirdY) + BS >= SH) || (BirdY == 0)
              || pipe_hit(int'(PipeX1), int'(PipeY1))
              || pipe_hit(int'(PipeX2), int'(PipeY2));
          p1 = int'(PipeX1) + PW < int'(BirdX);
          p2 = int'(PipeX2) + PW < int'(BirdX);
          if (coll) begin
            m_st = 2; m_dc = 0;
          end else begin
            inc = int'(p1 && !m_f1) + int'(p2 && !m_f2);
            m_sc = (m_sc + inc > 9999) ? 9999 : m_sc + inc;
          end
          m_f1 = p1; m_f2 = p2;
        end
        m_tick = (m_run % TD == 0);
      end
      2: begin
        m_run++;
        m_tick = (m_run % TD == 0);
        if (t) begin
          m_dc++;
          if (m_dc == DT) begin
            m_st = 3; m_tick = 0;
            if (m_sc > m_hs) m_hs = m_sc;
          end
        end
      end
      default: begin
        m_tick = 0;
        if (ra) m_st = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [3:0] es;
    es = 4'b0001 << m_st;
    check("state", {q_End, q_Dying, q_Play, q_I}, es);
    check("tick", Tick, m_tick);
    check("score", Score, to_bcd(m_sc));
    check("hiscore", HighScore, to_bcd(m_hs));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      compare_all();
    end
  endtask

  task automatic safe();
    BirdX = 10'd100; BirdY = 10'd200;
    PipeX1 = 10'd600; PipeX2 = 10'd600;
    PipeY1 = 10'd150; PipeY2 = 10'd150;
    Start = 1'b0; Ack = 1'b0;
  endtask

  task automatic press_start();
    Start = 1'b1; run(1); Start = 1'b0; run(1);
  endtask

  task automatic press_ack();
    Ack = 1'b1; run(1); Ack = 1'b0; run(1);
  endtask

  task automatic pass_round(input bit both);
    PipeX1 = 10'd0;
    if (both) PipeX2 = 10'd0;
    run(TD);
    PipeX1 = 10'd600; PipeX2 = 10'd600;
    run(TD);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'($urandom % 2); Ack = 1'($urandom % 2);
    BirdX = 10'($urandom); BirdY = 10'($urandom);
    PipeX1 = 10'($urandom); PipeX2 = 10'($urandom);
    PipeY1 = 10'($urandom); PipeY2 = 10'($urandom);
    run(2);
    check("rst_qi", q_I, 1'b1);
    check("rst_score", Score, 16'h0000);
    check("rst_hs", HighScore, 16'h0000);
    check("rst_tick", Tick, 1'b0);
    Reset = 1'b0;
    safe();

    Start = 1'b1;
    run(100);
    check("hold_start", {q_End, q_Dying, q_Play, q_I}, 4'b0010);
    Start = 1'b0;

    for (int x = 300; x >= 52; x -= 8) begin
      PipeX1 = 10'(x); run(TD);
    end
    check("pass1", Score, 16'h0001);
    Ack = 1'b1; run(2); Ack = 1'b0; run(2);
    check("ack_in_play", q_Play, 1'b1);
    PipeX1 = 10'd600; run(TD);
    for (int x = 300; x >= 52; x -= 8) begin
      PipeX1 = 10'(x); run(TD);
    end
    check("pass2", Score, 16'h0002);

    PipeX1 = 10'd110; PipeY1 = 10'd150; BirdY = 10'd140;
    run(TD);
    check("pipe_hit", {q_End, q_Dying, q_Play, q_I}, 4'b0100);
    check("hit_noscore", Score, 16'h0002);
    run(DT * TD + 4);
    check("end1", q_End, 1'b1);
    check("hs1", HighScore, 16'h0002);
    press_ack();
    check("ack_end", q_I, 1'b1);
    check("score_kept", Score, 16'h0002);

    safe(); press_start();
    BirdY = 10'd460; run(TD);
    check("floor", q_Dying, 1'b1);
    run(DT * TD + 4);
    check("hs_keep", HighScore, 16'h0002);
    press_ack();

    safe(); press_start();
    BirdY = 10'd0; run(TD);
    check("ceiling", q_Dying, 1'b1);
    run(DT * TD + 4);
    press_ack();

    safe(); press_start();
    pass_round(1'b0);
    repeat (4) pass_round(1'b1);
    check("score9", Score, 16'h0009);
    pass_round(1'b1);
    check("score11", Score, 16'h0011);
    while (m_sc < 9999) pass_round(1'b1);
    repeat (2) pass_round(1'b1);
    check("sat", Score, 16'h9999);
    BirdY = 10'd460; run(TD);
    run(DT * TD + 4);
    check("hs_sat", HighScore, 16'h9999);
    press_ack();

    safe(); press_start();
    BirdY = 10'd460; run(TD + 2);
    check("dying_pre", q_Dying, 1'b1);
    Reset = 1'b1; run(1);
    check("rst_mid_qi", q_I, 1'b1);
    check("rst_mid_tick", Tick, 1'b0);
    check("rst_mid_hs", HighScore, 16'h0000);
    Reset = 1'b0; run(2);

    repeat (4000) begin
      if ($urandom % 8 == 0) begin
        Start = 1'($urandom % 2); Ack = 1'($urandom % 2);
      end
      if ($urandom % 16 == 0) begin
        BirdX = 10'($urandom_range(0, 700));
        BirdY = 10'($urandom_range(100, 300));
        PipeX1 = 10'($urandom_range(0, 700));
        PipeX2 = 10'($urandom_range(0, 700));
        PipeY1 = 10'($urandom_range(0, 400));
        PipeY2 = 10'($urandom_range(0, 400));
        if ($urandom % 4 == 0) BirdY = 10'($urandom);
      end
      run(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
Central sequencer for the Flappy Bird datapath. Owns the game state machine (INIT/PLAY/DYING/END) and generates the frame-rate Tick strobe that advances the bird and pipe movers. Runs bird-vs-pipe/floor/ceiling collision detection and the BCD score and high-score counters. Sits between the button inputs and the bird, pipe, VGA and seven-segment blocks in vga_top.

Parameters:
TICK_DIV, 1666666, Clk cycles per game tick (60 Hz at 100 MHz)
BIRD_SIZE, 20, bird square side in pixels
PIPE_W, 40, pipe width in pixels
GAP_H, 120, vertical gap height; gap spans PipeY .. PipeY+GAP_H-1
SCREEN_H, 480, visible lines
DYING_TICKS, 30, ticks spent in DYING before END

Ports:
Clk  in  1  system clock; single clock domain
Reset  in  1  synchronous, active-high
Start  in  1  button level; rising edge starts game
Ack  in  1  button level; rising edge leaves END
BirdX  in  10  bird left edge
BirdY  in  10  bird top edge
PipeX1, PipeX2  in  10 each  pipe left edges
PipeY1, PipeY2  in  10 each  gap top edges
Tick  out  1  one-cycle game-advance strobe
q_I, q_Play, q_Dying, q_End  out  1 each  one-hot state
Score  out  16  4-digit packed BCD
HighScore  out  16  4-digit packed BCD

Behaviour:
- Reset (sampled on Clk edge): state INIT, Tick 0, Score 0, HighScore 0, divider 0, edge registers 0, pass flags 0.
- Edge detect: Start and Ack registered once; rise = cur & ~prev. Level held high gives exactly one event.
- Divider runs only in PLAY and DYING; cleared on INIT->PLAY. Tick=1 for one cycle when divider reaches TICK_DIV-1, then divider wraps to 0. First Tick comes TICK_DIV cycles after entering PLAY. Tick=0 in INIT and END.
- Collision, evaluated combinationally, acted on only on a PLAY Tick. All sums 11 bits wide, no wrap. Collision if either:
  - Floor: BirdY+BIRD_SIZE >= SCREEN_H.
  - Ceiling: BirdY == 0.
  - Pipe n: BirdX+BIRD_SIZE > PipeXn and BirdX < PipeXn+PIPE_W, and (BirdY < PipeYn or BirdY+BIRD_SIZE > PipeYn+GAP_H).
- Scoring: passed_n = (PipeXn+PIPE_W < BirdX), sampled into a flag on each PLAY Tick. Score +1 for each pipe whose flag rises; both pipes rising on the same Tick give +2. A pipe respawning at the right clears its flag, so it can score again. Flags cleared on INIT->PLAY.
- Score is BCD with per-digit carry and saturates at 9999. Collision on a Tick has priority: no score increment that Tick.
- FSM:
  - INIT: on Start rise -> PLAY; clear Score.
  - PLAY: on Tick with collision -> DYING; load dying counter to 0.
  - DYING: count Ticks; on the DYING_TICKS-th Tick -> END. Score frozen.
  - END: on the transition into END, HighScore <= Score if Score > HighScore (packed-BCD unsigned compare). On Ack rise -> INIT.
- Ignored inputs: Start outside INIT, Ack outside END.
- Reset in any state, mid-tick included, forces INIT on the next edge. HighScore is cleared only by Reset.
- Outputs are registered; state outputs change the cycle after the triggering event.

Test Plan:
1. Reset held 2 cycles with other inputs random -> q_I=1, Score=0, HighScore=0, Tick=0. Hold Start=1 for 100 cycles -> exactly one INIT->PLAY transition. Use TICK_DIV=4 -> Tick every 4th cycle.
2. PLAY, BirdX=100, BirdY=200, PipeX1=300, PipeY1=150. Step PipeX1 down to 59 across Ticks -> Score=0x0001 on the Tick where PipeX1+40<100. Set PipeX1=600 then walk it back down again -> Score=0x0002.
3. Both pipes cross on the same Tick from Score=0x0009 -> Score=0x0011. Force Score to 0x9999 -> stays 0x9999.
4. BirdY=140 with PipeX1=110, PipeY1=150 -> DYING on that Tick with no score. After 30 Ticks -> q_End. HighScore takes Score if larger, otherwise unchanged.
5. BirdY=460 -> floor collision. BirdY=0 -> ceiling collision. Ack pulses in PLAY are ignored. Ack rise in END -> INIT; Score is kept until the next Start.
6. Assert Reset in DYING mid-divider -> INIT next cycle, Tick=0, HighScore=0.
